piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 clk  input  1  Rising-edge clock; the only clock.
REQ-003 RST  input  1  Asynchronous reset, active-low.
REQ-004 EN  input  1  Active-low shift enable; 0 = advance one bit per clk edge, 1 = hold.
REQ-005 p_in  input  [0:WIDTH-1]  Parallel word to transmit.
REQ-006 ld_valid  input  1  Source asserts when p_in holds a word to send.
REQ-007 ld_ready  output  1  Block can accept a word this cycle.
REQ-008 s_out  output  1  Serial data out.
REQ-009 s_vld  output  1  s_out carries a valid frame bit this cycle.
REQ-010 done  output  1  One-cycle pulse after the last bit of a word is shifted.

Function
REQ-011 The block SHALL have two states: IDLE and SHIFT.
REQ-012 A load SHALL occur on a rising clk edge where ld_valid=1 and ld_ready=1; p_in is captured into shift register sr[0:WIDTH-1].
REQ-013 ld_ready SHALL be 1 in IDLE, and 1 in SHIFT only when the bit count is WIDTH-1 and EN=0 (last-bit cycle); otherwise 0.
REQ-014 A load from IDLE SHALL move to SHIFT, clear the bit counter, and set s_vld=1 from the following cycle.
REQ-015 Bit order SHALL be p_in[WIDTH-1] first down to p_in[0] last, so that the matching serial-in receiver holds the original word after WIDTH shifts.
REQ-016 s_out SHALL equal sr[WIDTH-1] while s_vld=1, and 0 while s_vld=0.
REQ-017 In SHIFT with EN=0, each edge SHALL shift sr toward the higher index (sr[i] <= sr[i-1], sr[0] <= 0) and increment the counter.
REQ-018 In SHIFT with EN=1, sr, counter, and outputs SHALL hold; a pause of any length SHALL NOT lose or duplicate bits.
REQ-019 On the edge that shifts out bit WIDTH-1: done=1 for the next cycle; when a load occurs on that edge, stay in SHIFT with the counter at 0 (back-to-back, no gap in s_vld); otherwise go to IDLE with s_vld=0.
REQ-020 ld_valid while ld_ready=0 SHALL be ignored; p_in is sampled only on the load edge.
REQ-021 A word shall occupy exactly WIDTH EN=0 cycles of s_vld=1.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap mid-word.

Reset
REQ-023 RST=0 SHALL asynchronously force: state IDLE, sr=0, counter=0, s_out=0, s_vld=0, done=0; ld_ready=1 after release.
REQ-024 Reset during SHIFT SHALL abort the word with no done pulse.
REQ-025 After RST rises, the first load SHALL be accepted on the first clk edge with ld_valid=1.

Structure
REQ-026 State encoding (IDLE/SHIFT) and the default WIDTH constant SHALL live in a shared package used by both the serializer and the serial-in receiver.
REQ-027 The design SHALL be a single module; no sub-module is required.

Verification
REQ-028 Reset then load 8'b1011_0010 (p_in[0:7]) with EN=0 -> s_out sequence p_in[7]..p_in[0] = 0,1,0,0,1,1,0,1 over 8 cycles, done pulse once, then IDLE.
REQ-029 Loopback: drive s_out into the serial-in receiver (shared clk, its EN tied to ~s_vld) -> receiver holds the loaded word after 8 valid bits.
REQ-030 EN=1 for 3 cycles after bit 3 of word 8'hA5 -> s_out holds bit 3 for 4 cycles total, remaining bits intact, done after 8 EN=0 cycles.
REQ-031 Back-to-back: ld_valid held with 8'hF0 then 8'h0F -> 16 contiguous s_vld cycles, two done pulses 8 cycles apart.
REQ-032 RST=0 asynchronously mid-word (bit 4) -> s_vld, s_out, done drop immediately; next load restarts from the first bit.
REQ-033 ld_valid pulsed mid-word (ld_ready=0) with a new p_in -> ignored; current word unchanged.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// ============================================================================
// piso_serializer_pkg : state encoding and default word width shared by the
//                       serializer and its matching serial-in receiver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package piso_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/piso_serializer_rx.sv
// ============================================================================
// piso_serializer_rx : serial-in receiver matching piso_serializer bit order;
//                      holds the transmitted word after WIDTH enabled shifts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_serializer_rx
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             i_en_n,
   input  logic             i_s_in,
   output logic [0:WIDTH-1] o_p_out
);

   logic [0:WIDTH-1] r_sr;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_sr <= '0;
      end else if (!i_en_n) begin
         r_sr <= {i_s_in, r_sr[0:WIDTH-2]};
      end
   end

   assign o_p_out = r_sr;

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer : parallel-in serial-out shifter with valid/ready load,
//                   active-low shift enable and end-of-word done pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             EN,
   input  logic [0:WIDTH-1] p_in,
   input  logic             ld_valid,
   output logic             ld_ready,
   output logic             s_out,
   output logic             s_vld,
   output logic             done
);

   localparam int               C_CNT_W = $clog2(WIDTH);
   localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [0:WIDTH-1]     r_sr;
   logic [0:WIDTH-1]     w_sr_nxt;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [C_CNT_W-1:0]   w_cnt_nxt;
   logic                 r_done;
   logic                 w_last;
   logic                 w_load;

   // Last-bit cycle: the coming edge shifts out the final bit and may reload.
   assign w_last   = (r_state == ST_SHIFT) && !EN && (r_cnt == C_LAST);
   assign ld_ready = (r_state == ST_IDLE) || w_last;
   assign w_load   = ld_valid && ld_ready;

   assign s_vld = (r_state == ST_SHIFT);
   assign s_out = s_vld && r_sr[WIDTH-1];
   assign done  = r_done;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_last;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_load) begin
               w_state_nxt = ST_SHIFT;
               w_sr_nxt    = p_in;
               w_cnt_nxt   = '0;
            end
         end
         ST_SHIFT: begin
            if (!EN) begin
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (w_load) begin
                     w_sr_nxt = p_in;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_sr_nxt    = '0;
                  end
               end else begin
                  w_sr_nxt  = {1'b0, r_sr[0:WIDTH-2]};
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// tb_piso_serializer : table-driven bench for piso_serializer with the
//                      matching receiver in loopback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         RST = 1'b0;
   logic         EN = 1'b1;
   logic [0:W-1] p_in = '0;
   logic         ld_valid = 1'b0;
   logic         ld_ready;
   logic         s_out;
   logic         s_vld;
   logic         done;
   logic [0:W-1] rx_word;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .RST      (RST),
      .EN       (EN),
      .p_in     (p_in),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .s_out    (s_out),
      .s_vld    (s_vld),
      .done     (done)
   );

   piso_serializer_rx #(.WIDTH(W)) u_rx (
      .clk     (clk),
      .RST     (RST),
      .i_en_n  (~s_vld),
      .i_s_in  (s_out),
      .o_p_out (rx_word)
   );

   typedef struct {
      logic         rst;
      logic         en;
      logic         ldv;
      logic [0:W-1] p;
      logic [3:0]   exp;   // {ld_ready, s_vld, s_out, done}
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic en, input logic ldv,
                      input logic [0:W-1] p, input logic [3:0] exp);
      vec_t v;
      v.rst = rst; v.en = en; v.ldv = ldv; v.p = p; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic en, input logic ldv,
                        input logic [0:W-1] p);
      RST = rst; EN = en; ld_valid = ldv; p_in = p;
   endtask

   task automatic check(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {ld_ready, s_vld, s_out, done};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: ready/vld/out/done got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [0:W-1] exp);
      checks++;
      if (rx_word !== exp) begin
         errors++;
         $display("FAIL %s: rx word got %h expected %h", name, rx_word, exp);
      end
   endtask

   logic [0:W-1] wa, wb, wc, wd, wf;
   logic [0:W-1] stream_a;   // bits of wa in transmission order

   initial begin
      wa = 8'b1011_0010;
      wb = 8'hA5;
      wc = 8'hF0;
      wd = 8'h0F;
      wf = 8'hFF;
      stream_a = 8'b0100_1101;

      // reset, then single word wa with EN=0 throughout
      add(0, 1, 0, '0, 4'b1000);
      add(1, 0, 1, wa, 4'b1000);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b1110);
      add(1, 0, 0, '0, 4'b1001);
      add(1, 0, 0, '0, 4'b1000);
      // wb with pause on bit 3 and ignored load attempts mid-word
      add(1, 0, 1, wb, 4'b1000);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 1, wf, 4'b0110);
      add(1, 1, 0, '0, 4'b0100);
      add(1, 1, 1, wf, 4'b0100);
      add(1, 1, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 1, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b1110);
      add(1, 0, 0, '0, 4'b1001);
      // back-to-back wc then wd, ld_valid held
      add(1, 0, 1, wc, 4'b1000);
      add(1, 0, 1, wd, 4'b0100);
      add(1, 0, 1, wd, 4'b0100);
      add(1, 0, 1, wd, 4'b0100);
      add(1, 0, 1, wd, 4'b0100);
      add(1, 0, 1, wd, 4'b0110);
      add(1, 0, 1, wd, 4'b0110);
      add(1, 0, 1, wd, 4'b0110);
      add(1, 0, 1, wd, 4'b1110);
      add(1, 0, 0, '0, 4'b0111);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0110);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b0100);
      add(1, 0, 0, '0, 4'b1100);
      add(1, 0, 0, '0, 4'b1001);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].en, vecs[i].ldv, vecs[i].p);
         #1;
         check($sformatf("row%0d", i), vecs[i].exp);
      end
      check_word("loopback_wd", wd);

      // asynchronous reset during bit 4 of wa, then a clean restart
      @(negedge clk);
      drive(1, 0, 1, wa);
      #1 check("rst_load", 4'b1000);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         drive(1, 0, 0, '0);
         #1 check($sformatf("pre_rst_bit%0d", k), {1'b0, 1'b1, stream_a[k], 1'b0});
      end
      #2 RST = 1'b0;
      #1 check("async_rst", 4'b1000);
      @(negedge clk);
      drive(1, 0, 0, '0);
      #1 check("post_rst_idle", 4'b1000);
      @(negedge clk);
      #1 check("post_rst_no_done", 4'b1000);
      drive(1, 0, 1, wa);
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         drive(1, 0, 0, '0);
         #1 check($sformatf("restart_bit%0d", k), {(k == W - 1), 1'b1, stream_a[k], 1'b0});
      end
      @(negedge clk);
      #1 check("restart_done", 4'b1001);
      check_word("loopback_wa", wa);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
